// File: rtl/bcd_serial_addsub_pkg.sv
// bcd_pkg: BCD constants, FSM state type and nine's-complement helper shared by bcd_serial_addsub.
package bcd_pkg;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;
    typedef enum logic [1:0] {IDLE, RUN, DONE} bcd_state_t;
    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction
endpackage

// File: rtl/bcd_serial_addsub_if.sv
// bcd_serial_addsub_if: start/busy/done request bus with operands and BCD result.
interface bcd_serial_addsub_if #(parameter int DIGITS = 4);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   s;
    logic                  cout;
    logic                  neg;
    logic                  err;
    modport master (output start, sub, a, b, input busy, done, s, cout, neg, err);
    modport slave  (input start, sub, a, b, output busy, done, s, cout, neg, err);
endinterface

// File: rtl/bcd_serial_addsub_digit_add.sv
// bcd_digit_add: combinational single-digit BCD add with carry-in; bad flags a digit above 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       bad
);
    logic [4:0] t;
    assign t    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign cout = t > {1'b0, BCD_MAX};
    assign s    = cout ? t[3:0] + BCD_ADJ : t[3:0];
    // a nine's-complemented invalid digit is itself still above 9, so this also covers subtraction
    assign bad  = (a > BCD_MAX) | (b > BCD_MAX);
endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD add/subtract, LSD first, one digit per clock.
// Define BCD_DIGIT_CHECK_EN to flag invalid operand digits on err and zero the result.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input logic               clk,
    input logic               rst,
    bcd_serial_addsub_if.slave bus
);
    localparam int CNT_W = $clog2(DIGITS) + 1;
    localparam int W     = 4 * DIGITS;

    bcd_state_t        state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d, s_q, s_d;
    logic              sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, neg_q, neg_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [3:0]        dsum;
    logic              dcout, bad, err_run, last;

    bcd_digit_add u_add (
        .a    (a_q[3:0]),
        .b    (sub_q ? nines_comp(b_q[3:0]) : b_q[3:0]),
        .cin  (carry_q),
        .s    (dsum),
        .cout (dcout),
        .bad  (bad)
    );

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;
    assign err_run = err_q | bad;
    assign bus.err = err_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && bus.start) err_d = 1'b0;
        else if (state_q == RUN)          err_d = err_run;
    end
`else
    logic unused_bad;
    assign unused_bad = bad;
    assign err_run    = 1'b0;
    assign bus.err    = 1'b0;
`endif

    assign last     = idx_q == CNT_W'(DIGITS - 1);
    assign bus.busy = state_q != IDLE;
    assign bus.done = state_q == DONE;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.neg  = neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_d     = bus.a;
                b_d     = bus.b;
                sub_d   = bus.sub;
                carry_d = bus.sub;
                s_d     = '0;
                cout_d  = 1'b0;
                neg_d   = 1'b0;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // operands shift right so the current digit is always in bits [3:0]
                a_d                  = a_q >> 4;
                b_d                  = b_q >> 4;
                carry_d              = dcout;
                s_d[4*idx_q +: 4]    = dsum;
                idx_d                = idx_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    cout_d  = dcout & ~err_run;
                    neg_d   = sub_q & ~dcout & ~err_run;
                    s_d     = err_run ? '0 : s_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
